reset_sequencer: RTL and testbench

//  Owns the processor/bus reset lines. Arbitrates reset requests from NUM_REQ sources
//  (host command, watchdog, button, debug), coalesces simultaneous ones, and runs a

---
 rtl/reset_seq_pkg.sv | 13 +
 rtl/reset_sequencer_if.sv | 16 +
 rtl/req_edge_capture.sv | 28 ++
 rtl/reset_sequencer.sv | 116 +++++++++++
 tb/tb_reset_sequencer.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/reset_seq_pkg.sv
// Shared state encodings and counter helpers for the reset sequencer.
package reset_seq_pkg;
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] HOLD    = 2'd1;
  localparam logic [1:0] STAGGER = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  localparam logic [7:0] SEQ_COUNT_MAX = 8'd255;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == SEQ_COUNT_MAX) ? v : v + 8'd1;
  endfunction
endpackage

// File: rtl/reset_sequencer_if.sv
// Request/ack and reset-line bundle between command logic and the sequencer.
interface reset_sequencer_if #(parameter int NUM_REQ = 4);
  logic [NUM_REQ-1:0] req_i;
  logic [NUM_REQ-1:0] ack_o;
  logic               busy_o;
  logic               bus_reset_o;
  logic               core_reset_o;
  logic               core_resetn_o;
  logic [NUM_REQ-1:0] cause_o;
  logic [7:0]         seq_count_o;

  modport master (input req_i, output ack_o, busy_o, bus_reset_o, core_reset_o,
                  core_resetn_o, cause_o, seq_count_o);
  modport slave  (output req_i, input ack_o, busy_o, bus_reset_o, core_reset_o,
                  core_resetn_o, cause_o, seq_count_o);
endinterface

// File: rtl/req_edge_capture.sv
// Rising-edge detect on request lines and accumulation into a pending mask.
module req_edge_capture #(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               acc_en,
  input  logic               take,
  output logic [NUM_REQ-1:0] req_edge,
  output logic [NUM_REQ-1:0] pending
);
  logic [NUM_REQ-1:0] req_q;

  assign req_edge = req & ~req_q;

  // req_q resets to ones so a level held through reset is not seen as an edge
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q   <= '1;
      pending <= '0;
    end else begin
      req_q <= req;
      if (take)        pending <= req_edge;
      else if (acc_en) pending <= pending | req_edge;
    end
  end
endmodule

// File: rtl/reset_sequencer.sv
// Arbitrates reset requests and drives the timed bus/core reset release sequence.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int HOLD_CYCLES    = 20,
  parameter int STAGGER_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  reset_sequencer_if.master     rs
);
  localparam int CNT_MAX = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] HOLD_LAST    = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] STAGGER_LAST = CW'(STAGGER_CYCLES - 1);

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic [NUM_REQ-1:0] grant, req_edge, pending;
  logic [NUM_REQ-1:0] ack_q, cause_q;
  logic [7:0]         seq_count_q;
  logic               busy_q, bus_reset_q, core_reset_q;
  logic               take, acc_en;

  assign take   = (state == IDLE) && (pending != '0);
  assign acc_en = (state != HOLD);

  req_edge_capture #(.NUM_REQ(NUM_REQ)) u_cap (
    .clk      (clk),
    .rst      (rst),
    .req      (rs.req_i),
    .acc_en   (acc_en),
    .take     (take),
    .req_edge (req_edge),
    .pending  (pending)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= HOLD;
      cnt          <= '0;
      bus_reset_q  <= 1'b1;
      core_reset_q <= 1'b1;
      busy_q       <= 1'b1;
      grant        <= '0;
      ack_q        <= '0;
      cause_q      <= '0;
      seq_count_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          ack_q <= '0;
          if (pending != '0) begin
            grant        <= pending;
            bus_reset_q  <= 1'b1;
            core_reset_q <= 1'b1;
            busy_q       <= 1'b1;
            cnt          <= '0;
            state        <= HOLD;
          end
        end
        HOLD: begin
          // a late requester joins the running sequence and restarts the hold
          if (req_edge != '0) begin
            grant <= grant | req_edge;
            cnt   <= '0;
          end else if (cnt == HOLD_LAST) begin
            bus_reset_q <= 1'b0;
            cnt         <= '0;
            state       <= STAGGER;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STAGGER: begin
          if (cnt == STAGGER_LAST) begin
            core_reset_q <= 1'b0;
            ack_q        <= grant;
            cnt          <= '0;
            state        <= DONE;
            if (grant != '0) begin
              cause_q     <= grant;
              seq_count_q <= sat_inc8(seq_count_q);
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          ack_q  <= '0;
          busy_q <= 1'b0;
          grant  <= '0;
          state  <= IDLE;
        end
        default: begin
          bus_reset_q  <= 1'b1;
          core_reset_q <= 1'b1;
          busy_q       <= 1'b1;
          ack_q        <= '0;
          grant        <= '0;
          cnt          <= '0;
          state        <= HOLD;
        end
      endcase
    end
  end

  assign rs.ack_o         = ack_q;
  assign rs.busy_o        = busy_q;
  assign rs.bus_reset_o   = bus_reset_q;
  assign rs.core_reset_o  = core_reset_q;
  assign rs.core_resetn_o = ~core_reset_q;
  assign rs.cause_o       = cause_q;
  assign rs.seq_count_o   = seq_count_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: power-on, single, coalesce, late, level, abort, saturation.
module tb_reset_sequencer;
  logic clk = 1'b0;
  logic rst;
  int   vec = 0;
  int   err = 0;

  reset_sequencer_if #(.NUM_REQ(4)) rs ();

  reset_sequencer #(.NUM_REQ(4), .HOLD_CYCLES(20), .STAGGER_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .rs  (rs)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; rs.req_i = 4'b0000;
    tick(3);
    vec++; if (rs.bus_reset_o !== 1'b1) begin err++; $display("FAIL rst_bus got %b want 1", rs.bus_reset_o); end
    vec++; if (rs.core_reset_o !== 1'b1) begin err++; $display("FAIL rst_core got %b want 1", rs.core_reset_o); end
    vec++; if (rs.core_resetn_o !== 1'b0) begin err++; $display("FAIL rst_coren got %b want 0", rs.core_resetn_o); end
    vec++; if (rs.busy_o !== 1'b1) begin err++; $display("FAIL rst_busy got %b want 1", rs.busy_o); end
    vec++; if (rs.ack_o !== 4'b0000) begin err++; $display("FAIL rst_ack got %b want 0000", rs.ack_o); end
    vec++; if (rs.cause_o !== 4'b0000) begin err++; $display("FAIL rst_cause got %b want 0000", rs.cause_o); end
    vec++; if (rs.seq_count_o !== 8'd0) begin err++; $display("FAIL rst_count got %0d want 0", rs.seq_count_o); end
    rst = 1'b0;
    tick(19);
    vec++; if (rs.bus_reset_o !== 1'b1) begin err++; $display("FAIL por_bus_hold got %b want 1", rs.bus_reset_o); end
    tick(1);
    vec++; if (rs.bus_reset_o !== 1'b0 || rs.core_reset_o !== 1'b1) begin err++;
      $display("FAIL por_bus_release got bus=%b core=%b want bus=0 core=1", rs.bus_reset_o, rs.core_reset_o); end
    tick(3);
    vec++; if (rs.core_reset_o !== 1'b1) begin err++; $display("FAIL por_stagger got %b want 1", rs.core_reset_o); end
    tick(1);
    vec++; if (rs.core_reset_o !== 1'b0 || rs.core_resetn_o !== 1'b1 || rs.ack_o !== 4'b0000 || rs.busy_o !== 1'b1) begin err++;
      $display("FAIL por_core_release got core=%b n=%b ack=%b busy=%b want 0 1 0000 1",
               rs.core_reset_o, rs.core_resetn_o, rs.ack_o, rs.busy_o); end
    tick(1);
    vec++; if (rs.busy_o !== 1'b0 || rs.seq_count_o !== 8'd0) begin err++;
      $display("FAIL por_done got busy=%b count=%0d want 0 0", rs.busy_o, rs.seq_count_o); end
  endtask

  task automatic test_single;
    rs.req_i = 4'b0010;
    tick(21);
    vec++; if (rs.bus_reset_o !== 1'b1 || rs.busy_o !== 1'b1) begin err++;
      $display("FAIL single_hold got bus=%b busy=%b want 1 1", rs.bus_reset_o, rs.busy_o); end
    tick(1);
    vec++; if (rs.bus_reset_o !== 1'b0 || rs.core_reset_o !== 1'b1) begin err++;
      $display("FAIL single_bus got bus=%b core=%b want 0 1", rs.bus_reset_o, rs.core_reset_o); end
    tick(3);
    vec++; if (rs.ack_o !== 4'b0000) begin err++; $display("FAIL single_early_ack got %b want 0000", rs.ack_o); end
    tick(1);
    vec++; if (rs.ack_o !== 4'b0010 || rs.core_reset_o !== 1'b0 || rs.busy_o !== 1'b1) begin err++;
      $display("FAIL single_ack got ack=%b core=%b busy=%b want 0010 0 1", rs.ack_o, rs.core_reset_o, rs.busy_o); end
    vec++; if (rs.cause_o !== 4'b0010 || rs.seq_count_o !== 8'd1) begin err++;
      $display("FAIL single_cause got cause=%b count=%0d want 0010 1", rs.cause_o, rs.seq_count_o); end
    tick(1);
    vec++; if (rs.ack_o !== 4'b0000 || rs.busy_o !== 1'b0) begin err++;
      $display("FAIL single_done got ack=%b busy=%b want 0000 0", rs.ack_o, rs.busy_o); end
    rs.req_i = 4'b0000;
    tick(2);
  endtask

  task automatic test_coalesce;
    rs.req_i = 4'b0001;
    tick(12);
    rs.req_i = 4'b0101;
    tick(20);
    vec++; if (rs.bus_reset_o !== 1'b1) begin err++; $display("FAIL coal_hold got %b want 1", rs.bus_reset_o); end
    tick(1);
    vec++; if (rs.bus_reset_o !== 1'b0) begin err++; $display("FAIL coal_bus got %b want 0", rs.bus_reset_o); end
    tick(3);
    vec++; if (rs.ack_o !== 4'b0000) begin err++; $display("FAIL coal_early_ack got %b want 0000", rs.ack_o); end
    tick(1);
    vec++; if (rs.ack_o !== 4'b0101 || rs.cause_o !== 4'b0101 || rs.seq_count_o !== 8'd2) begin err++;
      $display("FAIL coal_ack got ack=%b cause=%b count=%0d want 0101 0101 2", rs.ack_o, rs.cause_o, rs.seq_count_o); end
    tick(1);
    vec++; if (rs.ack_o !== 4'b0000 || rs.busy_o !== 1'b0) begin err++;
      $display("FAIL coal_done got ack=%b busy=%b want 0000 0", rs.ack_o, rs.busy_o); end
    rs.req_i = 4'b0000;
    tick(2);
  endtask

  task automatic test_late;
    rs.req_i = 4'b0001;
    tick(23);
    rs.req_i = 4'b1001;
    tick(3);
    vec++; if (rs.ack_o !== 4'b0001 || rs.seq_count_o !== 8'd3) begin err++;
      $display("FAIL late_first_ack got ack=%b count=%0d want 0001 3", rs.ack_o, rs.seq_count_o); end
    tick(25);
    vec++; if (rs.ack_o !== 4'b0000 || rs.busy_o !== 1'b1) begin err++;
      $display("FAIL late_gap got ack=%b busy=%b want 0000 1", rs.ack_o, rs.busy_o); end
    tick(1);
    vec++; if (rs.ack_o !== 4'b1000 || rs.cause_o !== 4'b1000 || rs.seq_count_o !== 8'd4) begin err++;
      $display("FAIL late_second_ack got ack=%b cause=%b count=%0d want 1000 1000 4", rs.ack_o, rs.cause_o, rs.seq_count_o); end
    tick(1);
    vec++; if (rs.busy_o !== 1'b0) begin err++; $display("FAIL late_done got busy=%b want 0", rs.busy_o); end
    rs.req_i = 4'b0000;
    tick(2);
  endtask

  task automatic test_level;
    logic [3:0] ack_seen;
    ack_seen = 4'b0000;
    rs.req_i = 4'b0010;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      ack_seen |= rs.ack_o;
    end
    vec++; if (ack_seen !== 4'b0000 || rs.busy_o !== 1'b0 || rs.seq_count_o !== 8'd0) begin err++;
      $display("FAIL level_held got ack_seen=%b busy=%b count=%0d want 0000 0 0", ack_seen, rs.busy_o, rs.seq_count_o); end
    rs.req_i = 4'b0000;
    tick(2);
    rs.req_i = 4'b0010;
    tick(25);
    vec++; if (rs.ack_o !== 4'b0000) begin err++; $display("FAIL level_early_ack got %b want 0000", rs.ack_o); end
    tick(1);
    vec++; if (rs.ack_o !== 4'b0010 || rs.seq_count_o !== 8'd1) begin err++;
      $display("FAIL level_reraise got ack=%b count=%0d want 0010 1", rs.ack_o, rs.seq_count_o); end
    tick(1);
    rs.req_i = 4'b0000;
    tick(2);
  endtask

  task automatic test_abort;
    logic [3:0] ack_seen;
    ack_seen = 4'b0000;
    rs.req_i = 4'b0100;
    tick(9);
    rst = 1'b1;
    tick(1);
    vec++; if (rs.bus_reset_o !== 1'b1 || rs.busy_o !== 1'b1 || rs.seq_count_o !== 8'd0) begin err++;
      $display("FAIL abort_rst got bus=%b busy=%b count=%0d want 1 1 0", rs.bus_reset_o, rs.busy_o, rs.seq_count_o); end
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      ack_seen |= rs.ack_o;
    end
    vec++; if (ack_seen !== 4'b0000 || rs.busy_o !== 1'b0 || rs.cause_o !== 4'b0000 || rs.seq_count_o !== 8'd0) begin err++;
      $display("FAIL abort_noack got ack_seen=%b busy=%b cause=%b count=%0d want 0000 0 0000 0",
               ack_seen, rs.busy_o, rs.cause_o, rs.seq_count_o); end
    rs.req_i = 4'b0000;
    tick(2);
  endtask

  task automatic test_saturate;
    for (int i = 0; i < 300; i++) begin
      rs.req_i = 4'b0001;
      tick(1);
      rs.req_i = 4'b0000;
      tick(27);
      if (i == 254) begin
        vec++; if (rs.seq_count_o !== 8'd255) begin err++;
          $display("FAIL sat_reach got %0d want 255", rs.seq_count_o); end
      end
    end
    vec++; if (rs.seq_count_o !== 8'd255 || rs.cause_o !== 4'b0001) begin err++;
      $display("FAIL sat_hold got count=%0d cause=%b want 255 0001", rs.seq_count_o, rs.cause_o); end
  endtask

  initial begin
    rst = 1'b1;
    rs.req_i = 4'b0000;
    @(negedge clk);
    test_reset();
    test_single();
    test_coalesce();
    test_late();
    test_level();
    test_abort();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
